pb_conditioner: RTL and testbench
=================================

# pb_conditioner

Input conditioning stage directly upstream of the synthesizer core. Takes the raw 16 breakout-board pushbutton pins and synchronizes, debounces and edge-detects them. It then priority-encodes the held keys into a single note index with a valid flag. The synthesizer core consumes `keys_clean`, the press/release strobes and `note`/`note_valid` instead of raw pins.

## Interface
- `NKEYS`, 16: number of pushbutton inputs; `NOTE_W = $clog2(NKEYS)`.
- `TICK_DIV`, 10000: sample-tick period in `hwclk` cycles (1 ms at 10 MHz); must be ≥ 2.
- `SAMPLES`, 4: consecutive agreeing samples required to change a key's debounced state; must be ≥ 2.

- `hwclk` in 1: system clock; sole clock.
- `nrst` in 1: reset, asynchronous assert, active-low.
- `pb` in NKEYS: raw pushbuttons, active-high, asynchronous to `hwclk`.
- `keys_clean` out NKEYS: debounced key levels.
- `key_pressed` out NKEYS: one-cycle strobe per key on debounced rise.
- `key_released` out NKEYS: one-cycle strobe per key on debounced fall.
- `note` out NOTE_W: selected key index.
- `note_valid` out 1: at least one key held; `note` meaningful only when high.

## Operation
- Synchronizer: two flops per bit; `pb_s` is `pb` delayed two cycles.
- Tick counter: free-runs `0..TICK_DIV-1` and wraps. `tick` is high on the cycle the count equals `TICK_DIV-1`.
- Per key: history register of `SAMPLES-1` bits, shifted with `pb_s[i]` on each `tick`.
  - On a `tick` edge, if `pb_s[i]` and all stored history bits are equal and differ from `keys_clean[i]`, `keys_clean[i]` takes that value on the same edge.
  - A single disagreeing sample restarts qualification.
- Strobes (registered):
  - `key_pressed[i]` is high for exactly one cycle, the cycle after `keys_clean[i]` goes 0→1.
  - `key_released[i]` is high for exactly one cycle after `keys_clean[i]` goes 1→0.
  - A press and a release of different keys may strobe in the same cycle.
- Note selection (registered, computed from `keys_clean`): default priority is the highest-index held key.
  - `note_valid = |keys_clean`, registered alongside `note`.
  - When no key is held, `note` holds its last value and `note_valid` = 0.
- Simultaneous qualification of several keys on one tick:
  - All update together.
  - Strobes for all of them fire in the same cycle.

## Timing
- Reset values:
  - `keys_clean`, `key_pressed`, `key_released`, `note`, `note_valid`, history, synchronizer flops: all 0.
  - Tick counter: 0.
- Reset mid-operation clears all state immediately (asynchronous).
  - No strobes fire on reset or on reset release.
  - Keys held through reset release re-qualify normally, producing `key_pressed` after the debounce time.
- Debounce latency, clean edge on `pb` to `keys_clean` change:
  - Minimum `2 + (SAMPLES-1)*TICK_DIV + 1` cycles.
  - Maximum `2 + SAMPLES*TICK_DIV` cycles.
- `key_pressed`/`key_released`, `note`, `note_valid`: each lags `keys_clean` by exactly 1 cycle.
- Pulses on `pb` shorter than `(SAMPLES-1)*TICK_DIV` cycles never change `keys_clean`.

## Configuration
- `PB_LAST_NOTE_PRIORITY_EN`
  - Defined: the block keeps a `last_key` register, loaded with the index of any key whose debounced rise occurs. If several rise together, the highest index wins.
    - `note` = `last_key` while that key is still held.
    - When `last_key` is released while others remain held, `note` falls back to the highest-index held key, and `last_key` is updated to it.
  - Undefined: pure highest-index priority; no `last_key` register is built.

## Test plan
Bench uses `TICK_DIV=4`, `SAMPLES=3`.
- Reset: hold `nrst`=0 with `pb`=16'hFFFF → all outputs 0.
  - Release reset → `keys_clean`=16'hFFFF within 14 cycles.
  - Single 1-cycle `key_pressed`=16'hFFFF.
- Clean press: `pb[5]` 0→1 → `keys_clean[5]` rises 11–14 cycles later.
  - `key_pressed`=16'h0020 for one cycle after that.
  - `note`=5, `note_valid`=1 on the same cycle.
- Bounce: `pb[3]` toggles every 3 cycles for 40 cycles then stays 0 → `keys_clean[3]` never rises; no strobes.
- Priority: hold key 2, then key 9 → `note`=9.
  - Release 9 → `key_released`=16'h0200 one cycle, then `note`=2.
  - Release 2 → `note_valid`=0, `note` stays 2.
- Macro defined: hold key 9, then press key 2 → `note`=2.
  - Release 2 → `note`=9.
- Reset mid-debounce: assert `nrst` during qualification of `pb[0]` → `keys_clean`=0 immediately; no strobe at reset release.

Source files
------------

// File: rtl/pb_conditioner.sv
// Purpose : synchronize, debounce and edge-detect NKEYS raw pushbuttons, then pick one held key as the note.
// Latency : 2-cycle synchronizer plus SAMPLES agreeing samples (tick every TICK_DIV cycles); strobes/note lag keys_clean by 1.
// Backpressure: none; the outputs are levels and single-cycle strobes that the consumer samples every cycle.
//
// Ports: hwclk (sole clock), nrst (async active-low reset), pb[NKEYS] (raw buttons, asynchronous),
//        keys_clean[NKEYS] (debounced levels), key_pressed/key_released[NKEYS] (1-cycle strobes),
//        note[NOTE_W] + note_valid (selected key while at least one key is held).
// Optional: define PB_LAST_NOTE_PRIORITY_EN for last-pressed-key priority; the default is highest-index priority.
module pb_conditioner #(
    parameter int NKEYS    = 16,
    parameter int TICK_DIV = 10000,
    parameter int SAMPLES  = 4,
    localparam int NOTE_W  = $clog2(NKEYS)
) (
    input  logic              hwclk,
    input  logic              nrst,
    input  logic [NKEYS-1:0]  pb,
    output logic [NKEYS-1:0]  keys_clean,
    output logic [NKEYS-1:0]  key_pressed,
    output logic [NKEYS-1:0]  key_released,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HIST_W = SAMPLES - 1;

    logic [NKEYS-1:0]             pb_m;
    logic [NKEYS-1:0]             pb_s;
    logic [CNT_W-1:0]             tick_cnt;
    logic                         tick;
    logic [NKEYS-1:0][HIST_W-1:0] hist;
    logic [NKEYS-1:0]             qual_hi;
    logic [NKEYS-1:0]             qual_lo;
    logic [NKEYS-1:0]             keys_prev;
    logic [NKEYS-1:0]             keys_rise;
    logic [NKEYS-1:0]             keys_fall;
    logic [NOTE_W-1:0]            held_top;
    logic [NOTE_W-1:0]            note_sel;

    // Two-flop synchronizer and free-running sample-tick counter.
    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            pb_m     <= '0;
            pb_s     <= '0;
            tick_cnt <= '0;
        end else begin
            pb_m     <= pb;
            pb_s     <= pb_m;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // A key qualifies when the current sample and every stored sample agree.
    always_comb begin
        qual_hi = '0;
        qual_lo = '0;
        for (int i = 0; i < NKEYS; i++) begin
            qual_hi[i] = pb_s[i] & (&hist[i]);
            qual_lo[i] = ~pb_s[i] & ~(|hist[i]);
        end
    end

    // History shifts in pb_s on each tick; bit 0 is the newest stored sample.
    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            hist       <= '0;
            keys_clean <= '0;
        end else if (tick) begin
            for (int i = 0; i < NKEYS; i++) begin
                hist[i][0] <= pb_s[i];
                for (int j = 1; j < HIST_W; j++) begin
                    hist[i][j] <= hist[i][j-1];
                end
            end
            keys_clean <= (keys_clean | qual_hi) & ~qual_lo;
        end
    end

    assign keys_rise = keys_clean & ~keys_prev;
    assign keys_fall = ~keys_clean & keys_prev;

    // keys_prev starts at 0 with keys_clean, so reset release can never strobe.
    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            keys_prev    <= '0;
            key_pressed  <= '0;
            key_released <= '0;
        end else begin
            keys_prev    <= keys_clean;
            key_pressed  <= keys_rise;
            key_released <= keys_fall;
        end
    end

    always_comb begin
        held_top = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (keys_clean[i]) held_top = NOTE_W'(i);
        end
    end

`ifdef PB_LAST_NOTE_PRIORITY_EN
    logic [NOTE_W-1:0] last_key;
    logic [NOTE_W-1:0] rise_top;

    always_comb begin
        rise_top = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (keys_rise[i]) rise_top = NOTE_W'(i);
        end
    end

    // A fresh rise wins; otherwise keep the last key while held, else fall back to the top held key.
    always_comb begin
        note_sel = last_key;
        if (|keys_rise) begin
            note_sel = rise_top;
        end else if (keys_clean[last_key]) begin
            note_sel = last_key;
        end else if (|keys_clean) begin
            note_sel = held_top;
        end
    end

    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            last_key <= '0;
        end else begin
            last_key <= note_sel;
        end
    end
`else
    assign note_sel = held_top;
`endif

    // note keeps its last value while nothing is held.
    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            note       <= '0;
            note_valid <= 1'b0;
        end else begin
            note_valid <= |keys_clean;
            if (|keys_clean) note <= note_sel;
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Purpose : randomized and directed stimulus for pb_conditioner, checked every cycle against a run-length reference model.
// Latency : model and DUT are compared 1 time unit after every rising edge.
// Backpressure: none.
module tb_pb_conditioner;

    localparam int NKEYS    = 16;
    localparam int TICK_DIV = 4;
    localparam int SAMPLES  = 3;

    logic        hwclk = 1'b0;
    logic        nrst  = 1'b0;
    logic [15:0] pb    = '0;
    logic [15:0] keys_clean;
    logic [15:0] key_pressed;
    logic [15:0] key_released;
    logic [3:0]  note;
    logic        note_valid;

    int checks   = 0;
    int failures = 0;

    pb_conditioner #(.NKEYS(NKEYS), .TICK_DIV(TICK_DIV), .SAMPLES(SAMPLES)) dut (
        .hwclk        (hwclk),
        .nrst         (nrst),
        .pb           (pb),
        .keys_clean   (keys_clean),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .note         (note),
        .note_valid   (note_valid)
    );

    always #5 hwclk = ~hwclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per key, the length of the current run of equal tick samples.
    logic [15:0] m_s1, m_s2, m_clean, m_prev, m_pr, m_rl;
    logic [3:0]  m_note, m_lastkey;
    logic        m_valid;
    int          m_cnt;
    int          m_run [NKEYS];
    logic        m_lastv [NKEYS];

    function automatic logic [3:0] top_bit(input logic [15:0] v);
        logic [3:0] t;
        t = '0;
        for (int i = 0; i < NKEYS; i++) if (v[i]) t = 4'(i);
        return t;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_prev = '0; m_pr = '0; m_rl = '0;
        m_note = '0; m_lastkey = '0; m_valid = 1'b0; m_cnt = 0;
        // Reset history is all zeros: a run of SAMPLES-1 zero samples.
        for (int k = 0; k < NKEYS; k++) begin
            m_run[k]   = SAMPLES - 1;
            m_lastv[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [15:0] rise;
        logic [3:0]  sel;
        logic        s;
        rise = m_clean & ~m_prev;
        m_pr = rise;
        m_rl = ~m_clean & m_prev;
`ifdef PB_LAST_NOTE_PRIORITY_EN
        if (rise != 0)                 sel = top_bit(rise);
        else if (m_clean[m_lastkey])   sel = m_lastkey;
        else if (m_clean != 0)         sel = top_bit(m_clean);
        else                           sel = m_lastkey;
        m_lastkey = sel;
`else
        sel = top_bit(m_clean);
`endif
        if (m_clean != 0) m_note = sel;
        m_valid = (m_clean != 0);
        m_prev  = m_clean;
        if (m_cnt == TICK_DIV - 1) begin
            for (int k = 0; k < NKEYS; k++) begin
                s = m_s2[k];
                if (s == m_lastv[k]) begin
                    if (m_run[k] < SAMPLES) m_run[k]++;
                end else begin
                    m_run[k]   = 1;
                    m_lastv[k] = s;
                end
                if (m_run[k] >= SAMPLES && s != m_clean[k]) m_clean[k] = s;
            end
        end
        m_s2  = m_s1;
        m_s1  = pb;
        m_cnt = (m_cnt + 1) % TICK_DIV;
    endtask

    task automatic compare_all();
        check("keys_clean",   32'(keys_clean),   32'(m_clean));
        check("key_pressed",  32'(key_pressed),  32'(m_pr));
        check("key_released", 32'(key_released), 32'(m_rl));
        check("note_valid",   32'(note_valid),   32'(m_valid));
        check("note",         32'(note),         32'(m_note));
    endtask

    task automatic step();
        @(posedge hwclk);
        if (nrst) model_step();
        else      model_reset();
        #1;
        compare_all();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int lat, presses, bad, found;
        int r;
        model_reset();

        // Reset with every button held.
        pb = 16'hFFFF;
        nrst = 1'b0;
        settle(3);
        check("rst_keys_clean", 32'(keys_clean), 32'h0);
        check("rst_pressed",    32'(key_pressed), 32'h0);
        check("rst_note_valid", 32'(note_valid), 32'h0);
        check("rst_note",       32'(note), 32'h0);
        nrst = 1'b1;
        lat = 0; presses = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (keys_clean == 16'hFFFF && lat == 0) lat = c;
            if (key_pressed != 0) begin
                presses++;
                check("rst_press_val", 32'(key_pressed), 32'hFFFF);
            end
        end
        check("rst_qualify_in_14", 32'(lat >= 1 && lat <= 14), 32'd1);
        check("rst_press_count", 32'(presses), 32'd1);

        // Clean press of key 5.
        pb = '0;
        settle(20);
        check("idle_clean", 32'(keys_clean), 32'h0);
        pb[5] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            step();
            if (keys_clean[5]) lat = c;
        end
        check("k5_latency_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
        step();
        check("k5_pressed", 32'(key_pressed), 32'h0020);
        check("k5_note", 32'(note), 32'd5);
        check("k5_valid", 32'(note_valid), 32'd1);
        step();
        check("k5_pressed_once", 32'(key_pressed), 32'h0);

        // Bouncing key 3 must never qualify.
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            pb[3] = (c < 40) ? (((c / 3) % 2) == 0) : 1'b0;
            step();
            if (keys_clean[3] || key_pressed[3] || key_released[3]) bad++;
        end
        check("bounce_k3_quiet", 32'(bad), 32'd0);
        pb = '0;
        settle(20);

        // Priority: 2 then 9, release 9, release 2.
        pb = 16'h0004; settle(20);
        pb = 16'h0204; settle(20);
        check("prio_note9", 32'(note), 32'd9);
        check("prio_valid", 32'(note_valid), 32'd1);
        pb = 16'h0004;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            step();
            if (key_released != 0) begin
                found = 1;
                check("rel9_strobe", 32'(key_released), 32'h0200);
                check("rel9_note2", 32'(note), 32'd2);
            end
        end
        check("rel9_seen", 32'(found), 32'd1);
        settle(5);
        pb = '0; settle(20);
        check("none_valid", 32'(note_valid), 32'd0);
        check("none_note_hold", 32'(note), 32'd2);

        // Hold 9, then press 2.
        pb = 16'h0200; settle(20);
        pb = 16'h0204; settle(20);
`ifdef PB_LAST_NOTE_PRIORITY_EN
        check("last_note2", 32'(note), 32'd2);
`else
        check("high_note9", 32'(note), 32'd9);
`endif
        pb = 16'h0200; settle(20);
        check("back_note9", 32'(note), 32'd9);
        pb = '0; settle(20);

        // Random traffic: sparse single flips plus occasional multi-key changes.
        for (int c = 0; c < 2500; c++) begin
            r = $urandom_range(0, 63);
            if (r < 4) begin
                r = $urandom_range(0, 15);
                pb[r] = ~pb[r];
            end else if (r == 4) begin
                pb = pb ^ 16'($urandom());
            end
            step();
        end
        pb = '0; settle(20);

        // Reset during qualification of key 0 while key 7 is held.
        pb = 16'h0080; settle(20);
        check("pre_rst_k7", 32'(keys_clean), 32'h0080);
        pb = 16'h0081;
        settle(6);
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        check("midrst_clean", 32'(keys_clean), 32'h0);
        check("midrst_valid", 32'(note_valid), 32'h0);
        settle(3);
        nrst = 1'b1;
        presses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (key_pressed != 0 || key_released != 0) presses++;
        end
        check("rst_release_no_strobe", 32'(presses), 32'd0);
        settle(20);
        check("requalify_clean", 32'(keys_clean), 32'h0081);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
